// File: rtl/music_defs_pkg.sv
// Shared definitions for the music datapath: default field widths, sequencer
// state encodings and the end-of-melody marker.
package music_defs;

  localparam int DEF_DUR_W   = 11;
  localparam int DEF_PITCH_W = 8;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_LOAD  = 3'd2;
  localparam logic [STATE_W-1:0] S_ARM   = 3'd3;
  localparam logic [STATE_W-1:0] S_PLAY  = 3'd4;
  localparam logic [STATE_W-1:0] S_GAP   = 3'd5;
  localparam logic [STATE_W-1:0] S_END   = 3'd6;

  // A ROM entry whose duration equals this value terminates the melody.
  localparam int DUR_END = 0;

endpackage

// File: rtl/note_sequencer.sv
// Melody sequencer: fetches {pitch, duration} entries from a synchronous ROM and
// hands each one to the note delay timer, waiting on its active flag per note.
module note_sequencer
  import music_defs::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DUR_W   = DEF_DUR_W,
  parameter int PITCH_W = DEF_PITCH_W,
  parameter int GAP     = 2,
  parameter int ARM_TO  = 15,
  parameter int LOOP    = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [PITCH_W+DUR_W-1:0] rom_data,
  output logic [DUR_W-1:0]         dly_dur,
  output logic                     dly_en,
  input  logic                     dly_active,
  output logic [PITCH_W-1:0]       pitch,
  output logic                     note_on,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_MAX = (GAP > ARM_TO) ? GAP : ARM_TO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cnt;
  logic [PITCH_W-1:0] rom_pitch;
  logic [DUR_W-1:0]   rom_dur;
  logic               last_addr;
  logic               cnt_last;

  assign rom_pitch = rom_data[PITCH_W+DUR_W-1 -: PITCH_W];
  assign rom_dur   = rom_data[DUR_W-1:0];
  assign last_addr = &rom_addr;
  assign cnt_last  = (cnt <= CNT_W'(1));

  // Handshake outputs are pure state decodes, so stop/reset drop them on the same edge.
  assign dly_en  = (state == S_ARM) || (state == S_PLAY);
  assign note_on = (state == S_PLAY);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rom_addr <= '0;
      dly_dur  <= '0;
      pitch    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop && (state != S_IDLE) && (state != S_END)) begin
        state <= S_END;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !stop) begin
              rom_addr <= '0;
              state    <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            dly_dur <= rom_dur;
            pitch   <= rom_pitch;
            if (rom_dur == DUR_W'(DUR_END)) begin
              state <= S_END;
            end else begin
              state <= S_ARM;
              cnt   <= CNT_W'(ARM_TO);
            end
          end
          S_ARM: begin
            // A late dly_active on the final ARM cycle still wins over the timeout.
            if (dly_active) begin
              state <= S_PLAY;
            end else if (cnt_last) begin
              state <= S_GAP;
              cnt   <= CNT_W'(GAP);
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          S_PLAY: begin
            if (!dly_active) begin
              state <= S_GAP;
              cnt   <= CNT_W'(GAP);
            end
          end
          S_GAP: begin
            if (!cnt_last) begin
              cnt <= cnt - CNT_W'(1);
            end else if (!last_addr) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_FETCH;
            end else if (LOOP != 0) begin
              rom_addr <= '0;
              state    <= S_FETCH;
            end else begin
              state <= S_END;
            end
          end
          S_END: begin
            done     <= 1'b1;
            rom_addr <= '0;
            dly_dur  <= '0;
            pitch    <= '0;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
